pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage that sits directly upstream of the instruction memory in the single-cycle MIPS datapath.
- Holds the architectural PC and drives the instruction-memory word address each cycle.
- Computes the next PC from sequential, branch, jump and jump-register requests supplied by the control/ALU stages.
- Tracks run/halt/fault status and counts retired instructions.

Parameters:
- pcWidth, 32, width of the byte-address PC.
- length, 256, instruction memory depth in words; the word address is $clog2(length) bits.
- resetVector, 32'h0000_0000, byte address loaded on reset; must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold the PC this cycle; no retire.
- halt  input  1  decoded halt/syscall; enter HALTED.
- branchTaken  input  1  conditional branch resolved taken.
- branchImm  input  16  signed word offset from the instruction.
- jump  input  1  J/JAL.
- jumpTarget  input  26  instruction index field.
- jumpReg  input  1  JR/JALR.
- regTarget  input  pcWidth  register-sourced byte target.
- programCounter  output  $clog2(length)  word address to instruction memory, pc[$clog2(length)+1:2].
- pc  output  pcWidth  current byte PC.
- pcPlus4  output  pcWidth  pc+4, for JAL link.
- running  output  1  state is RUN.
- fault  output  1  state is FAULT.
- retired  output  32  retired-instruction count.

Behaviour:
- Reset is asynchronous and active-low:
  - Assertion immediately forces pc=resetVector, retired=0, state=BOOT, running=0, fault=0.
  - Applies mid-operation with no ordering constraint on other inputs.
- State machine:
  - BOOT: exactly one cycle after reset deasserts. PC is held and nothing retires. Next state is RUN.
  - RUN: the normal case. The PC register updates each edge using the priority order below.
  - HALTED: PC frozen, running=0, retired frozen. Exited only by reset.
  - FAULT: PC frozen at the offending instruction, fault=1. Exited only by reset.
- Next-PC priority in RUN, highest first:
  1. stall: PC held, no retire. Stall takes priority over halt, so halt is only sampled on non-stalled cycles.
  2. halt: next state HALTED, PC held, the halt instruction counts as retired.
  3. jumpReg: target is regTarget.
  4. jump: target is {pcPlus4[31:28], jumpTarget, 2'b00}.
  5. branchTaken: target is pcPlus4 + (sign-extended branchImm << 2). Arithmetic is modulo 2^pcWidth.
  6. default: pcPlus4.
- Simultaneous requests: the highest priority wins and the rest are ignored. This covers jumpReg with jump, and jump with branchTaken.
- Fault check on the chosen next PC:
  - Fault if next PC[1:0] != 0 (misaligned jumpReg target), or next PC >> 2 >= length (out of range).
  - On fault: go to FAULT, PC not updated, faulting instruction not retired.
- retired:
  - Increments by 1 on each RUN cycle that is not stalled and does not fault, including the halt cycle.
  - Wraps from 32'hFFFF_FFFF to 0.
- Outputs are combinational from registers only (no input-to-output paths): programCounter, pc, pcPlus4.
  - Instruction memory is combinational, so the instruction for pc is valid in the same cycle.
- pc wraps modulo 2^pcWidth. Any wrap whose result lands at or beyond length faults under the range rule.

Decomposition:
- Shared package (mips_pkg):
  - State enum BOOT/RUN/HALTED/FAULT.
  - Opcode-independent constants: INSTR_BYTES=4, JUMP_REGION_BITS=4.
  - Function sext16 for sign-extending branchImm.
- One sub-module: pc_next_mux. Purely combinational; computes the target and the misalign/range fault flags.
- pc_fetch_unit holds the FSM, the PC register and the retire counter.

Test Plan:
- Reset then 4 free-running cycles, no requests → pc goes 0x0 (BOOT), 0x0, 0x4, 0x8, 0xC; retired=3; programCounter=3.
- At pc=0x10, branchTaken=1, branchImm=16'hFFFC → next pc=0x04. Then at pc=0x04 with jump=1, jumpTarget=26'h40 → pc=0x100.
- At pc=0x20, jumpReg=1, regTarget=0x22 → FAULT, pc stays 0x20, fault=1, retired unchanged. Later jump inputs are ignored until rst_n pulses low.
- At pc=0x3F8 (length=256 → last valid word at 0x3FC): advance → 0x3FC. Next increment to 0x400 → FAULT.
- stall=1 for 3 cycles at pc=0x8 → pc and retired held. With stall=1, halt=1, branchTaken=1 in the same cycle: stall wins and no state change. Then halt=1 alone → HALTED, retired+1, pc frozen.
- rst_n driven low mid-cycle while in RUN at pc=0x40 → outputs reset immediately without waiting for a clock edge; after release, BOOT then RUN from 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types, constants and helpers for the MIPS fetch stage.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  localparam int INSTR_BYTES      = 4;
  localparam int JUMP_REGION_BITS = 4;

  // Sign-extend a 16-bit instruction immediate to a full 32-bit word.
  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: picks the redirect target by priority and flags
// targets that are misaligned or lie beyond the end of instruction memory.
// The J-type target layout assumes a 32-bit PC (4 region bits + 26 + 2).
module pc_next_mux
  import mips_pkg::*;
#(
  parameter int pcWidth = 32,
  parameter int length  = 256
) (
  input  logic [pcWidth-1:0] pc,
  input  logic               branchTaken,
  input  logic [15:0]        branchImm,
  input  logic               jump,
  input  logic [25:0]        jumpTarget,
  input  logic               jumpReg,
  input  logic [pcWidth-1:0] regTarget,
  output logic [pcWidth-1:0] pcPlus4,
  output logic [pcWidth-1:0] nextPc,
  output logic               misaligned,
  output logic               outOfRange
);

  logic [pcWidth-1:0] branchOffset;
  logic [pcWidth-1:0] jumpAddr;
  logic [pcWidth-1:0] wordIndex;

  assign pcPlus4      = pc + pcWidth'(INSTR_BYTES);
  assign branchOffset = pcWidth'(sext16(branchImm)) << 2;
  assign jumpAddr     = {pcPlus4[pcWidth-1 -: JUMP_REGION_BITS], jumpTarget, 2'b00};

  // Priority select of the redirect target; lower-priority requests are ignored.
  always_comb begin
    nextPc = pcPlus4;
    if (jumpReg) begin
      nextPc = regTarget;
    end else if (jump) begin
      nextPc = jumpAddr;
    end else if (branchTaken) begin
      nextPc = pcPlus4 + branchOffset;
    end
  end

  assign wordIndex  = nextPc >> 2;
  assign misaligned = (nextPc[1:0] != 2'b00);
  assign outOfRange = (wordIndex >= pcWidth'(length));

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, run/halt/fault state machine and retired-instruction
// counter for the single-cycle MIPS fetch stage.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int                 pcWidth     = 32,
  parameter int                 length      = 256,
  parameter logic [pcWidth-1:0] resetVector = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       halt,
  input  logic                       branchTaken,
  input  logic [15:0]                branchImm,
  input  logic                       jump,
  input  logic [25:0]                jumpTarget,
  input  logic                       jumpReg,
  input  logic [pcWidth-1:0]         regTarget,
  output logic [$clog2(length)-1:0]  programCounter,
  output logic [pcWidth-1:0]         pc,
  output logic [pcWidth-1:0]         pcPlus4,
  output logic                       running,
  output logic                       fault,
  output logic [31:0]                retired
);

  localparam int addrWidth = $clog2(length);

  fetch_state_t       state;
  fetch_state_t       stateNext;
  logic [pcWidth-1:0] pcNext;
  logic [pcWidth-1:0] targetPc;
  logic               misaligned;
  logic               outOfRange;
  logic               retireEn;

  pc_next_mux #(
    .pcWidth(pcWidth),
    .length (length)
  ) u_next (
    .pc         (pc),
    .branchTaken(branchTaken),
    .branchImm  (branchImm),
    .jump       (jump),
    .jumpTarget (jumpTarget),
    .jumpReg    (jumpReg),
    .regTarget  (regTarget),
    .pcPlus4    (pcPlus4),
    .nextPc     (targetPc),
    .misaligned (misaligned),
    .outOfRange (outOfRange)
  );

  // Decide next state, next PC and whether the current instruction retires.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    retireEn  = 1'b0;
    case (state)
      BOOT: stateNext = RUN;
      RUN: begin
        if (stall) begin
          stateNext = RUN;
        end else if (halt) begin
          stateNext = HALTED;
          retireEn  = 1'b1;
        end else if (misaligned || outOfRange) begin
          stateNext = FAULT;
        end else begin
          pcNext   = targetPc;
          retireEn = 1'b1;
        end
      end
      HALTED: stateNext = HALTED;
      FAULT:  stateNext = FAULT;
      default: stateNext = FAULT;
    endcase
  end

  // State, PC and retire counter registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= resetVector;
      retired <= 32'd0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (retireEn) begin
        retired <= retired + 32'd1;
      end
    end
  end

  assign programCounter = pc[addrWidth+1:2];
  assign running        = (state == RUN);
  assign fault          = (state == FAULT);

endmodule
